// File: rtl/snd_pkg.sv
// Shared constants, ramp FSM state encodings and the mix saturator for the
// sound back-end.
package snd_pkg;

  localparam int SAMPLE_W = 16;
  localparam int GAIN_W   = 9;

  localparam logic [GAIN_W-1:0] GAIN_UNITY = 9'd256;
  localparam logic [3:0]        VOL_UNITY  = 4'd8;

  localparam logic [1:0] ST_MUTED     = 2'd0;
  localparam logic [1:0] ST_RAMP_UP   = 2'd1;
  localparam logic [1:0] ST_RUN       = 2'd2;
  localparam logic [1:0] ST_RAMP_DOWN = 2'd3;

  typedef struct packed {
    logic signed [SAMPLE_W-1:0] val;
    logic                       ovf;
  } sat_t;

  // Clamp an 18-bit sum to 16 bits; the top three bits agree only when it fits.
  function automatic sat_t sat18(input logic signed [17:0] x);
    sat_t r;
    r.ovf = 1'b0;
    r.val = x[15:0];
    if (x[17:15] != {3{x[17]}}) begin
      r.ovf = 1'b1;
      r.val = x[17] ? 16'sh8000 : 16'sh7FFF;
    end
    return r;
  endfunction

endpackage

// File: rtl/snd_dsm.sv
// First-order delta-sigma modulator: the accumulator carry is the 1-bit DAC
// output, with mean duty u/65536.
module snd_dsm (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] u_i,
  output logic        carry_o
);

  logic [15:0] acc_q;
  logic        carry_q;
  logic [16:0] sum;

  assign sum = {1'b0, acc_q} + {1'b0, u_i};

  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q   <= '0;
      carry_q <= 1'b0;
    end else begin
      acc_q   <= sum[15:0];
      carry_q <= sum[16];
    end
  end

  assign carry_o = carry_q;

endmodule

// File: rtl/snd_mix_dac.sv
// OPL2 + CMS mixer: per-source volume, saturating sum, anti-pop gain ramp and a
// 1-bit delta-sigma DAC replicated onto the snd pin bus.
module snd_mix_dac
  import snd_pkg::*;
#(
  parameter int RAMP_DIV = 256,
  parameter int OUT_W    = 7
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [15:0]      opl_sample,
  input  logic             opl_valid,
  input  logic [15:0]      cms_sample,
  input  logic             cms_valid,
  input  logic [3:0]       vol_opl,
  input  logic [3:0]       vol_cms,
  input  logic             mute,
  input  logic             clip_clr,
  output logic             clip,
  output logic             muted,
  output logic [OUT_W-1:0] snd
);

  localparam int DIV_W = $clog2(RAMP_DIV);

  // 16x4 product fits in 20 bits; >>>3 makes vol=8 unity.
  function automatic logic signed [16:0] scale_vol(input logic signed [15:0] s,
                                                   input logic [3:0] v);
    return 17'((20'(s) * 20'($signed({1'b0, v}))) >>> 3);
  endfunction

  function automatic logic signed [15:0] apply_gain(input logic signed [15:0] m,
                                                    input logic [GAIN_W-1:0] g);
    return 16'((26'(m) * 26'($signed({1'b0, g}))) >>> 8);
  endfunction

  logic signed [15:0] opl_q, cms_q;
  logic               vld_p0_q;
  logic signed [16:0] opl_p1_q, cms_p1_q;
  logic               vld_p1_q;
  logic signed [15:0] mix_p2_q;
  logic               vld_p2_q;
  logic signed [15:0] ramp_p3_q;
  logic               vld_p3_q;
  logic [15:0]        u;
  logic               carry;
  sat_t               sat_mix;
  logic               clip_q, clip_d;

  logic [1:0]         state_q, state_d;
  logic [GAIN_W-1:0]  g_q, g_d;
  logic [DIV_W-1:0]   div_q, div_d;

  assign sat_mix = sat18(18'(opl_p1_q) + 18'(cms_p1_q));
  assign clip_d  = sat_mix.ovf | (clip_q & ~clip_clr);

  always_ff @(posedge clk) begin
    if (reset) begin
      opl_q     <= '0;
      cms_q     <= '0;
      vld_p0_q  <= 1'b0;
      opl_p1_q  <= '0;
      cms_p1_q  <= '0;
      vld_p1_q  <= 1'b0;
      mix_p2_q  <= '0;
      vld_p2_q  <= 1'b0;
      ramp_p3_q <= '0;
      vld_p3_q  <= 1'b0;
      clip_q    <= 1'b0;
    end else begin
      // S0: capture
      if (opl_valid) opl_q <= opl_sample;
      if (cms_valid) cms_q <= cms_sample;
      vld_p0_q  <= opl_valid | cms_valid;
      // S1: volume
      opl_p1_q  <= scale_vol(opl_q, vol_opl);
      cms_p1_q  <= scale_vol(cms_q, vol_cms);
      vld_p1_q  <= vld_p0_q;
      // S2: saturating mix
      mix_p2_q  <= sat_mix.val;
      vld_p2_q  <= vld_p1_q;
      clip_q    <= clip_d;
      // S3: mute ramp gain
      ramp_p3_q <= apply_gain(mix_p2_q, g_q);
      vld_p3_q  <= vld_p2_q;
    end
  end

  // S4: offset binary for the DAC, midscale 0x8000 is silence.
  assign u = {~ramp_p3_q[15], ramp_p3_q[14:0]};

  // A direction change still applies the step due on that wrap, so the gain
  // never jumps and never repeats a level.
  always_comb begin
    state_d = state_q;
    g_d     = g_q;
    div_d   = '0;
    case (state_q)
      ST_MUTED: begin
        g_d = '0;
        if (!mute) state_d = ST_RAMP_UP;
      end
      ST_RAMP_UP: begin
        div_d = div_q + DIV_W'(1);
        if ((&div_q) && (g_q != GAIN_UNITY)) g_d = g_q + 9'd1;
        if (mute)                    state_d = ST_RAMP_DOWN;
        else if (g_d == GAIN_UNITY)  state_d = ST_RUN;
      end
      ST_RUN: begin
        g_d = GAIN_UNITY;
        if (mute) state_d = ST_RAMP_DOWN;
      end
      ST_RAMP_DOWN: begin
        div_d = div_q + DIV_W'(1);
        if ((&div_q) && (g_q != '0)) g_d = g_q - 9'd1;
        if (!mute)           state_d = ST_RAMP_UP;
        else if (g_d == '0)  state_d = ST_MUTED;
      end
      default: state_d = ST_MUTED;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_MUTED;
      g_q     <= '0;
      div_q   <= '0;
    end else begin
      state_q <= state_d;
      g_q     <= g_d;
      div_q   <= div_d;
    end
  end

  snd_dsm u_dsm (
    .clk     (clk),
    .reset   (reset),
    .u_i     (u),
    .carry_o (carry)
  );

  assign snd   = {OUT_W{carry}};
  assign clip  = clip_q;
  assign muted = (state_q == ST_MUTED);

endmodule

// File: tb/tb_snd_mix_dac.sv
// Directed bench for snd_mix_dac: a scoreboard checks each strobed sample at the
// DAC input, plus direct checks of ramp, clip, duty and reset behaviour.
module tb_snd_mix_dac;
  import snd_pkg::*;

  localparam int RAMP_DIV = 4;
  localparam int OUT_W    = 7;

  logic             clk = 1'b0;
  logic             reset;
  logic [15:0]      opl_sample, cms_sample;
  logic             opl_valid, cms_valid;
  logic [3:0]       vol_opl, vol_cms;
  logic             mute, clip_clr;
  logic             clip, muted;
  logic [OUT_W-1:0] snd;

  snd_mix_dac #(.RAMP_DIV(RAMP_DIV), .OUT_W(OUT_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .opl_sample (opl_sample),
    .opl_valid  (opl_valid),
    .cms_sample (cms_sample),
    .cms_valid  (cms_valid),
    .vol_opl    (vol_opl),
    .vol_cms    (vol_cms),
    .mute       (mute),
    .clip_clr   (clip_clr),
    .clip       (clip),
    .muted      (muted),
    .snd        (snd)
  );

  always #5 clk = ~clk;

  int          n_vec = 0;
  int          n_bad = 0;
  logic [15:0] exp_q[$];
  int          cur_opl = 0, cur_cms = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  function automatic logic [15:0] model_u(input int o, input int c, input int vo,
                                          input int vc, input int g);
    int a, b, s, m, r;
    a = (o * vo) >>> 3;
    b = (c * vc) >>> 3;
    s = a + b;
    m = (s > 32767) ? 32767 : ((s < -32768) ? -32768 : s);
    r = (m * g) >>> 8;
    return 16'(r + 32768);
  endfunction

  task automatic strobe(input logic [15:0] o, input logic ov,
                        input logic [15:0] c, input logic cv, input int g);
    opl_sample = o; opl_valid = ov;
    cms_sample = c; cms_valid = cv;
    if (ov) cur_opl = int'($signed(o));
    if (cv) cur_cms = int'($signed(c));
    exp_q.push_back(model_u(cur_opl, cur_cms, int'(vol_opl), int'(vol_cms), g));
    @(posedge clk); #1;
    opl_valid = 1'b0; cms_valid = 1'b0;
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    if (!reset && dut.vld_p3_q) begin
      if (exp_q.size() == 0) check("sb_unexpected", 32'(exp_q.size()), 32'd1);
      else check("sb_u", dut.u, exp_q.pop_front());
    end
  end

  // Gain-continuity tracker for the mute/unmute excursion
  logic track = 1'b0;
  int   gmin = 512, jumps = 0, muted_seen = 0, g_prev = 256;
  always @(negedge clk) begin
    if (track) begin
      if (int'(dut.g_q) < gmin) gmin = int'(dut.g_q);
      if ((int'(dut.g_q) - g_prev > 1) || (g_prev - int'(dut.g_q) > 1)) jumps++;
      if (muted) muted_seen++;
      g_prev = int'(dut.g_q);
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int ones, bad_rep;
    reset = 1'b1; mute = 1'b1; clip_clr = 1'b0;
    opl_sample = '0; cms_sample = '0; opl_valid = 1'b0; cms_valid = 1'b0;
    vol_opl = 4'd8; vol_cms = 4'd8;
    tick(3);
    @(negedge clk);
    check("rst_clip", clip, 1'b0);
    check("rst_muted", muted, 1'b1);
    check("rst_snd", snd, '0);
    check("rst_g", dut.g_q, 9'd0);
    check("rst_state", dut.state_q, ST_MUTED);

    // Muted: midscale gives an exact 50% alternating pattern
    @(posedge clk); #1 reset = 1'b0;
    @(posedge clk);
    ones = 0; bad_rep = 0;
    repeat (1000) begin
      @(negedge clk);
      ones += int'(snd[0]);
      if (snd != '0 && snd != {OUT_W{1'b1}}) bad_rep++;
    end
    check("mute_duty_ones", ones, 500);
    check("snd_replicated", bad_rep, 0);
    check("mute_g", dut.g_q, 9'd0);
    check("mute_muted", muted, 1'b1);

    // Load OPL 0x4000 while muted, then ramp up to RUN
    @(posedge clk); #1;
    strobe(16'h4000, 1'b1, 16'h0000, 1'b1, 0);
    tick(8);
    mute = 1'b0;
    repeat (1024) @(posedge clk);
    @(negedge clk);
    check("ramp_g_1023", dut.g_q, 9'd255);
    check("ramp_state_1023", dut.state_q, ST_RAMP_UP);
    @(posedge clk); @(negedge clk);
    check("ramp_g_1024", dut.g_q, 9'd256);
    check("ramp_state_run", dut.state_q, ST_RUN);
    check("run_muted", muted, 1'b0);
    tick(3);
    check("run_u_c000", dut.u, 16'hC000);
    ones = 0;
    repeat (1024) begin
      @(negedge clk);
      ones += int'(snd[0]);
    end
    check("duty75_ones", ones, 768);

    // Positive saturation and sticky clip
    @(posedge clk); #1;
    strobe(16'h7000, 1'b1, 16'h7000, 1'b1, 256);
    tick(6);
    check("sat_pos_mix", $unsigned(dut.mix_p2_q), 16'h7FFF);
    check("sat_pos_clip", clip, 1'b1);
    strobe(16'h0000, 1'b1, 16'h0000, 1'b1, 256);
    tick(6);
    check("clip_sticky", clip, 1'b1);
    clip_clr = 1'b1;
    tick(1);
    clip_clr = 1'b0;
    @(negedge clk);
    check("clip_cleared", clip, 1'b0);
    @(posedge clk); #1;
    clip_clr = 1'b1;
    strobe(16'h7000, 1'b1, 16'h7000, 1'b1, 256);
    tick(6);
    check("clip_sat_wins", clip, 1'b1);
    clip_clr = 1'b0;
    strobe(16'h0000, 1'b1, 16'h0000, 1'b1, 256);
    tick(6);
    clip_clr = 1'b1;
    tick(1);
    clip_clr = 1'b0;

    // Negative saturation with vol 15, then both volumes to zero
    vol_cms = 4'd15;
    strobe(16'h8000, 1'b1, 16'h8000, 1'b1, 256);
    tick(6);
    check("sat_neg_mix", $unsigned(dut.mix_p2_q), 16'h8000);
    check("sat_neg_clip", clip, 1'b1);
    check("sat_neg_u", dut.u, 16'h0000);
    vol_opl = 4'd0; vol_cms = 4'd0;
    tick(4);
    check("vol0_u", dut.u, 16'h8000);

    // Floor behaviour of the arithmetic shift and independent strobes
    vol_opl = 4'd3; vol_cms = 4'd15;
    strobe(16'hFFFB, 1'b1, 16'h1000, 1'b1, 256);
    tick(6);
    vol_opl = 4'd1; vol_cms = 4'd8;
    strobe(16'h0007, 1'b1, 16'hFFF9, 1'b1, 256);
    tick(6);
    vol_opl = 4'd8;
    strobe(16'h0123, 1'b1, 16'h0000, 1'b0, 256);
    tick(6);
    strobe(16'h0000, 1'b0, 16'hE000, 1'b1, 256);
    tick(6);

    // Simultaneous strobes and pipeline latency
    strobe(16'h0000, 1'b1, 16'h0000, 1'b1, 256);
    tick(6);
    strobe(16'h1000, 1'b1, 16'h2000, 1'b1, 256);
    @(posedge clk); @(negedge clk);
    check("lat_mix_n2", $unsigned(dut.mix_p2_q), 16'h0000);
    @(posedge clk); @(negedge clk);
    check("lat_mix_n3", $unsigned(dut.mix_p2_q), 16'h3000);
    check("lat_u_n3", dut.u, 16'h8000);
    @(posedge clk); @(negedge clk);
    check("lat_u_n4", dut.u, 16'hB000);
    tick(4);

    // Mute then unmute mid-ramp: continuous gain, never MUTED
    gmin = 512; jumps = 0; muted_seen = 0; g_prev = 256; track = 1'b1;
    @(posedge clk); #1 mute = 1'b1;
    repeat (100 * RAMP_DIV) @(posedge clk);
    #1 mute = 1'b0;
    tick(500);
    track = 1'b0;
    check("dip_gmin", gmin, 156);
    check("dip_jumps", jumps, 0);
    check("dip_never_muted", muted_seen, 0);
    check("dip_back_g", dut.g_q, 9'd256);
    check("dip_back_run", dut.state_q, ST_RUN);

    // Reset in the middle of a ramp
    reset = 1'b1; mute = 1'b1;
    tick(1);
    reset = 1'b0; mute = 1'b0;
    repeat (100) @(posedge clk);
    @(negedge clk);
    check("rampup_state", dut.state_q, ST_RAMP_UP);
    check("rampup_g", dut.g_q, 9'd24);
    reset = 1'b1;
    @(posedge clk); @(negedge clk);
    check("midrst_state", dut.state_q, ST_MUTED);
    check("midrst_g", dut.g_q, 9'd0);
    check("midrst_snd", snd, '0);
    check("midrst_muted", muted, 1'b1);
    reset = 1'b0;
    tick(2);

    check("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
